// File: rtl/load_store_unit_if.sv
// Word-wide data-memory bus between the load/store unit (master) and memory (slave).
// mem_rdata is valid in the same cycle as mem_ack for reads.
interface load_store_unit_if #(
  parameter int ADDR_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: runs one req/ack bus access per memory instruction, stalls the core meanwhile.
// Optional MISALIGN_TRAP_EN adds a misalign output and traps misaligned halfword/word accesses.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              MemRW,
  input  logic [2:0]        RSel,
  input  logic [1:0]        WSel,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic              done,
  output logic [31:0]       ld_data,
  output logic              timeout,
`ifdef MISALIGN_TRAP_EN
  output logic              misalign,
`endif
  load_store_unit_if.master bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, DONE = 2'd2} state_t;

  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT_CYCLES - 1);

  state_t            state_r, state_s;
  logic [7:0]        count_r;
  logic              we_r;
  logic [2:0]        rsel_r;
  logic [1:0]        lane_r;
  logic [ADDR_W-1:0] addr_r;
  logic [3:0]        be_r;
  logic [31:0]       wdata_r;
  logic [31:0]       ld_data_r;
  logic              timeout_r;
  logic              misalign_s;
  logic              accept_s;
  logic              req_s;

  function automatic logic [3:0] store_be(input logic [1:0] wsel, input logic [1:0] off);
    case (wsel)
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << {off[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [1:0] wsel, input logic [31:0] d);
    case (wsel)
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] extend_load(input logic [2:0] rsel, input logic [1:0] off,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (rsel)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return word;
    endcase
  endfunction

`ifdef MISALIGN_TRAP_EN
  logic half_s, word_s;

  // Classify the incoming access size for the alignment trap
  always_comb begin
    half_s = 1'b0;
    word_s = 1'b0;
    if (MemRW) begin
      half_s = (WSel == 2'b01);
      word_s = WSel[1];
    end else begin
      half_s = (RSel == 3'b001) || (RSel == 3'b101);
      word_s = !((RSel == 3'b000) || (RSel == 3'b001) || (RSel == 3'b100) || (RSel == 3'b101));
    end
  end

  assign misalign_s = rst_n && (state_r == IDLE) && start &&
                      ((half_s && addr[0]) || (word_s && (addr[1:0] != 2'b00)));
  assign misalign   = misalign_s;
`else
  assign misalign_s = 1'b0;
`endif

  assign accept_s = (state_r == IDLE) && start && !misalign_s;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_s;
  end

  // Next-state: ack wins over timeout even on the last allowed cycle
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_s = BUS;
        else          state_s = IDLE;
      end
      BUS: begin
        if (bus.mem_ack)               state_s = DONE;
        else if (count_r == LAST_CNT)  state_s = IDLE;
        else                           state_s = BUS;
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Core-facing handshake outputs decoded from state
  always_comb begin
    stall = 1'b0;
    done  = 1'b0;
    req_s = 1'b0;
    case (state_r)
      IDLE:    stall = start && rst_n;
      BUS: begin
        stall = 1'b1;
        req_s = 1'b1;
      end
      DONE:    done = 1'b1;
      default: stall = 1'b0;
    endcase
  end

  // Cycles spent waiting in BUS
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                count_r <= 8'd0;
    else if (state_r == BUS)   count_r <= count_r + 8'd1;
    else                       count_r <= 8'd0;
  end

  // Latch the request so the bus stays stable until ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_r    <= 1'b0;
      rsel_r  <= 3'd0;
      lane_r  <= 2'd0;
      addr_r  <= '0;
      be_r    <= 4'd0;
      wdata_r <= 32'd0;
    end else if (accept_s) begin
      we_r    <= MemRW;
      rsel_r  <= RSel;
      lane_r  <= addr[1:0];
      addr_r  <= {addr[ADDR_W-1:2], 2'b00};
      be_r    <= MemRW ? store_be(WSel, addr[1:0]) : 4'b1111;
      wdata_r <= MemRW ? store_data(WSel, wdata) : 32'd0;
    end
  end

  // Load result capture and timeout pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_data_r <= 32'd0;
      timeout_r <= 1'b0;
    end else begin
      timeout_r <= (state_r == BUS) && !bus.mem_ack && (count_r == LAST_CNT);
      if ((state_r == BUS) && bus.mem_ack && !we_r)
        ld_data_r <= extend_load(rsel_r, lane_r, bus.mem_rdata);
    end
  end

  assign ld_data       = ld_data_r;
  assign timeout       = timeout_r;
  assign bus.mem_req   = req_s;
  assign bus.mem_we    = we_r;
  assign bus.mem_addr  = addr_r;
  assign bus.mem_be    = be_r;
  assign bus.mem_wdata = wdata_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized scoreboard bench for load_store_unit with a behavioural memory responder.
module tb_load_store_unit;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n, start, MemRW;
  logic [2:0]  RSel;
  logic [1:0]  WSel;
  logic [31:0] addr, wdata;
  logic        stall, done, timeout;
  logic [31:0] ld_data;
`ifdef MISALIGN_TRAP_EN
  logic        misalign;
`endif

  load_store_unit_if #(.ADDR_W(32)) bus_if ();

  load_store_unit #(.TIMEOUT_CYCLES(TO), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .MemRW(MemRW), .RSel(RSel), .WSel(WSel),
    .addr(addr), .wdata(wdata), .stall(stall), .done(done), .ld_data(ld_data),
    .timeout(timeout),
`ifdef MISALIGN_TRAP_EN
    .misalign(misalign),
`endif
    .bus(bus_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic [2:0]  rsel;
    logic [1:0]  wsel;
    logic [31:0] a;
    logic [31:0] wd;
    int          wait_cyc;
    logic [31:0] rd;
  } op_t;

  typedef struct {
    logic [31:0] a;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wd;
    int          wait_cyc;
    logic [31:0] rd;
  } plan_t;

  typedef struct {
    logic        is_to;
    logic [31:0] ld;
  } exp_t;

  plan_t       plan_q[$];
  exp_t        exp_q[$];
  int          passed = 0;
  int          total  = 0;
  logic [31:0] model_ld = 32'd0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  function automatic logic [3:0] ref_be(input logic st, input logic [1:0] wsel, input logic [1:0] off);
    int unsigned o;
    o = off;
    if (!st) return 4'hF;
    if (wsel == 2'd0) return 4'(1 << o);
    if (wsel == 2'd1) return 4'(3 << (o & 2));
    return 4'hF;
  endfunction

  function automatic logic [31:0] ref_wd(input logic [1:0] wsel, input logic [31:0] d);
    if (wsel == 2'd0) return (d & 32'hFF) * 32'h01010101;
    if (wsel == 2'd1) return (d & 32'hFFFF) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] rsel, input logic [1:0] off, input logic [31:0] w);
    logic [31:0] b, h;
    int unsigned o;
    o = off;
    b = (w >> (8 * o)) & 32'hFF;
    h = (w >> (16 * (o / 2))) & 32'hFFFF;
    case (rsel)
      3'd0:    return (b >= 32'd128)   ? b - 32'd256   : b;
      3'd1:    return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  function automatic op_t mk(input logic st, input logic [2:0] rs, input logic [1:0] ws,
                             input logic [31:0] a, input logic [31:0] wd, input int w,
                             input logic [31:0] rd);
    op_t o;
    o.st = st; o.rsel = rs; o.wsel = ws; o.a = a; o.wd = wd; o.wait_cyc = w; o.rd = rd;
    return o;
  endfunction

  task automatic drive(input op_t o);
    start = 1'b1; MemRW = o.st; RSel = o.rsel; WSel = o.wsel; addr = o.a; wdata = o.wd;
  endtask

  // Issue one access at a negedge; returns at the negedge where done/timeout is seen.
  task automatic do_op(input op_t o);
    plan_t p;
    exp_t  e;
    int    cyc;
    int    exp_lat;
`ifdef MISALIGN_TRAP_EN
    logic  half, word;
    half = o.st ? (o.wsel == 2'd1) : (o.rsel == 3'd1 || o.rsel == 3'd5);
    word = o.st ? o.wsel[1] : !(o.rsel == 3'd0 || o.rsel == 3'd1 || o.rsel == 3'd4 || o.rsel == 3'd5);
    if ((half && o.a[0]) || (word && o.a[1:0] != 2'd0)) begin
      drive(o);
      #1;
      check("misalign_pulse", misalign, 1);
      check("misalign_stall", stall, 1);
      @(negedge clk);
      start = 1'b0;
      #1;
      check("misalign_clear", misalign, 0);
      check("misalign_no_req", bus_if.mem_req, 0);
      return;
    end
`endif
    p.a = o.a & 32'hFFFF_FFFC; p.be = ref_be(o.st, o.wsel, o.a[1:0]); p.we = o.st;
    p.wd = ref_wd(o.wsel, o.wd); p.wait_cyc = o.wait_cyc; p.rd = o.rd;
    plan_q.push_back(p);
    e.is_to = (o.wait_cyc < 0);
    if (!e.is_to && !o.st) model_ld = ref_load(o.rsel, o.a[1:0], o.rd);
    e.ld = model_ld;
    exp_q.push_back(e);
    exp_lat = (o.wait_cyc < 0) ? TO + 1 : o.wait_cyc + 2;
    drive(o);
    #1;
    check("stall_at_start", stall, 1);
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!(done || timeout) && cyc < TO + 6) begin
      check("stall_in_bus", stall, 1);
      @(negedge clk);
      cyc++;
    end
    check("latency", cyc, exp_lat);
    check("stall_released", stall, 0);
  endtask

  // Memory responder: checks the request against the plan and acks after the planned wait
  initial begin
    plan_t cur;
    int    waited = 0;
    int    reqs   = 0;
    bit    in_txn = 1'b0;
    cur.wait_cyc = -2;
    bus_if.mem_ack   = 1'b0;
    bus_if.mem_rdata = 32'd0;
    forever begin
      @(negedge clk);
      if (bus_if.mem_req) begin
        if (!in_txn) begin
          in_txn = 1'b1; waited = 0; reqs = 1;
          if (plan_q.size() == 0) begin
            total++;
            $display("FAIL bus_unplanned_req: got request at %0h expected none", bus_if.mem_addr);
            cur.wait_cyc = -2;
          end else begin
            cur = plan_q.pop_front();
            check("mem_addr", bus_if.mem_addr, cur.a);
            check("mem_be", bus_if.mem_be, cur.be);
            check("mem_we", bus_if.mem_we, cur.we);
            if (cur.we) check("mem_wdata", bus_if.mem_wdata, cur.wd);
          end
        end else begin
          waited++; reqs++;
        end
        if (cur.wait_cyc == waited) begin
          bus_if.mem_ack = 1'b1; bus_if.mem_rdata = cur.rd;
        end else begin
          bus_if.mem_ack = 1'b0; bus_if.mem_rdata = $urandom;
        end
      end else begin
        if (in_txn && cur.wait_cyc != -2)
          check("req_cycles", reqs, (cur.wait_cyc < 0) ? TO : cur.wait_cyc + 1);
        in_txn = 1'b0;
        bus_if.mem_ack   = 1'($urandom_range(0, 1));
        bus_if.mem_rdata = $urandom;
      end
    end
  end

  // Scoreboard monitor: pops an expectation on every done/timeout pulse
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && (done || timeout)) begin
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL unexpected_completion: got done=%0d timeout=%0d expected none", done, timeout);
        end else begin
          e = exp_q.pop_front();
          check("done_vs_timeout", {done, timeout}, e.is_to ? 2'b01 : 2'b10);
          check("ld_data", ld_data, e.ld);
        end
      end
    end
  end

  initial begin
    op_t o;
    rst_n = 1'b0; start = 1'b0; MemRW = 1'b0; RSel = 3'd0; WSel = 2'd0; addr = 32'd0; wdata = 32'd0;
    repeat (2) @(negedge clk);
    check("rst_stall", stall, 0);
    check("rst_done", done, 0);
    check("rst_timeout", timeout, 0);
    check("rst_req", bus_if.mem_req, 0);
    check("rst_be", bus_if.mem_be, 0);
    check("rst_addr", bus_if.mem_addr, 0);
    check("rst_ld", ld_data, 0);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(mk(1'b1, 3'd0, 2'd2, 32'h104, 32'hDEADBEEF, 0, 32'd0));
    @(negedge clk);
    do_op(mk(1'b1, 3'd0, 2'd0, 32'h203, 32'h000000A5, 1, 32'd0));
    @(negedge clk);
    do_op(mk(1'b0, 3'd0, 2'd0, 32'h302, 32'd0, 3, 32'h12F45678));
    @(negedge clk);
    do_op(mk(1'b0, 3'd4, 2'd0, 32'h302, 32'd0, 0, 32'h12F45678));
    @(negedge clk);
    do_op(mk(1'b0, 3'd5, 2'd0, 32'h302, 32'd0, 2, 32'h12F45678));
    @(negedge clk);
    do_op(mk(1'b0, 3'd2, 2'd0, 32'h400, 32'd0, -1, 32'd0));
    @(negedge clk);

    // start presented while in DONE must be ignored
    do_op(mk(1'b1, 3'd0, 2'd1, 32'h502, 32'h0000BEEF, 0, 32'd0));
    drive(mk(1'b1, 3'd0, 2'd2, 32'h600, 32'h11111111, 0, 32'd0));
    @(negedge clk);
    start = 1'b0;
    check("done_ignores_start", bus_if.mem_req, 0);
    @(negedge clk);
    check("done_ignores_start_next", bus_if.mem_req, 0);

    // reset during BUS
    o = mk(1'b0, 3'd2, 2'd0, 32'h700, 32'd0, -2, 32'd0);
    plan_q.push_back('{a: 32'h700, be: 4'hF, we: 1'b0, wd: 32'd0, wait_cyc: -2, rd: 32'd0});
    drive(o);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midbus_rst_req", bus_if.mem_req, 0);
    check("midbus_rst_stall", stall, 0);
    check("midbus_rst_ld", ld_data, 0);
    check("midbus_rst_be", bus_if.mem_be, 0);
    model_ld = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_done", done, 0);
    check("post_rst_timeout", timeout, 0);
    do_op(mk(1'b1, 3'd0, 2'd2, 32'h800, 32'hCAFEF00D, 0, 32'd0));
    @(negedge clk);
    do_op(mk(1'b0, 3'd2, 2'd0, 32'h102, 32'd0, 0, 32'h89ABCDEF));
    @(negedge clk);

    for (int i = 0; i < 60; i++) begin
      o = mk(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
             $urandom, $urandom, ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 3)),
             $urandom);
      do_op(o);
      @(negedge clk);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    check("plan_q_drained", plan_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Downstream of the single-cycle control unit; consumes its MemRW, RSel and WSel fields plus the ALU address and rs2 data.
- Runs each load/store as a req/ack transaction on a word-wide data-memory bus.
- Stalls the core (PC and register-file write) until the access completes or times out.
- Returns sign- or zero-extended load data for write-back.

Parameters:
TIMEOUT_CYCLES, 64, maximum cycles waiting for mem_ack before aborting (range 2..255)
ADDR_W, 32, byte-address width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  memory instruction present this cycle (load or store)
MemRW  in  1  1 = store, 0 = load
RSel  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU (others treated as LW)
WSel  in  2  store type: 00 SB, 01 SH, 10 SW, 11 treated as SW
addr  in  ADDR_W  byte address from ALU
wdata  in  32  rs2 value
stall  out  1  hold PC/RegWEn this cycle
done  out  1  one-cycle pulse: access finished
ld_data  out  32  extended load result, valid while done=1
timeout  out  1  one-cycle pulse: access aborted
mem_req  out  1  bus request
mem_we  out  1  bus write enable
mem_addr  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
mem_be  out  4  byte enables
mem_wdata  out  32  lane-replicated store data
mem_ack  in  1  bus completion; for reads, mem_rdata valid in the same cycle
mem_rdata  in  32  bus read data

Behaviour:
- Reset (async, rst_n=0): state=IDLE, counter=0. All outputs 0: stall, done, timeout, mem_req, mem_we, mem_be, mem_addr, mem_wdata, ld_data. No bus activity during reset.
- FSM states: IDLE, BUS, DONE.
- IDLE:
  - stall = start (combinational).
  - On start=1: latch MemRW, RSel/WSel, addr[1:0], word address and byte enables; go to BUS.
- BUS:
  - mem_req=1; mem_we/mem_addr/mem_be/mem_wdata held stable until ack; stall=1; counter increments each cycle.
  - mem_ack=1: capture and extend mem_rdata (loads), go to DONE.
  - counter reaches TIMEOUT_CYCLES-1 with no ack: drop mem_req, pulse timeout, go to IDLE. ld_data unchanged; no done pulse.
- DONE:
  - done=1, stall=0 (core advances this edge), mem_req=0; go to IDLE.
  - start is ignored in DONE. A back-to-back access begins the following cycle.
- Minimum latency with ack in the first BUS cycle: start at cycle 0, mem_req cycle 1, done cycle 2. A load therefore stalls for 2 cycles.
- Byte enables:
  - SB: 4'b0001 << addr[1:0].
  - SH: 4'b0011 << {addr[1],1'b0}.
  - SW: 4'b1111.
- mem_wdata: SB = {4{wdata[7:0]}}; SH = {2{wdata[15:0]}}; SW = wdata.
- Load extraction:
  - Byte lane = addr[1:0], halfword lane = addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
- ld_data holds its last value until the next successful load.
- Stores do not alter ld_data.
- Address alignment is always natural; low bits are ignored for halfword/word. Misaligned handling is covered under Optional Feature.
- mem_ack outside BUS is ignored.
- Reset asserted mid-BUS: request drops immediately, returns to IDLE, no done or timeout pulse.

Optional Feature:
MISALIGN_TRAP_EN
- Defined:
  - Adds output misalign (1 bit, reset 0).
  - In IDLE, start with a halfword at addr[0]=1, or a word at addr[1:0]!=0, skips BUS: misalign pulses for one cycle, stall=1 that cycle only, no mem_req, state stays IDLE.
- Undefined: port absent; misaligned accesses are silently naturally aligned as above.

Test Plan:
1. SW addr=0x104, wdata=0xDEADBEEF, ack in first BUS cycle -> mem_addr=0x104, mem_be=1111, mem_we=1; done in cycle 2; stall high cycles 0-1.
2. SB addr=0x203, wdata=0x000000A5 -> mem_be=1000, mem_wdata=0xA5A5A5A5, mem_addr=0x200.
3. LB addr=0x302, mem_rdata=0x12F45678, ack after 3 wait cycles -> ld_data=0xFFFFFFF4 with done. LBU at same address -> 0x000000F4. LHU addr=0x302 -> 0x000012F4.
4. Load with no ack, TIMEOUT_CYCLES=8 -> mem_req high exactly 8 cycles, timeout pulse, no done, ld_data unchanged.
5. rst_n dropped during BUS -> mem_req=0 asynchronously. After release: IDLE, all outputs 0, next SW completes normally.
6. MISALIGN_TRAP_EN defined, LW addr=0x102 -> misalign pulse, no mem_req. Undefined -> mem_addr=0x100, normal LW.
